zxuno_regbus_frontend: RTL and testbench

Z80 I/O front end for the ZX-Uno register bank. It decodes CPU accesses to the address port (0xFC3B) and the data port (0xFD3B). It filters the strobes and latches the selected register number. It then drives the shared register-bus signals (`zxuno_addr`, `regaddr_changed`, `zxuno_regrd`, `zxuno_regwr`) consumed by every register peripheral, including the multiboot/ICAP block. It also returns read data to the CPU data bus mux.

---
 rtl/zxuno_regbus_frontend.sv | 141 ++++++++++++++
 tb/tb_zxuno_regbus_frontend.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zxuno_regbus_frontend.sv
// Z80 I/O front end for the ZX-Uno register bank: decodes the address/data ports,
// filters strobes and drives the shared register bus. Option: ZXUNO_ADDR_READBACK_EN.
module zxuno_regbus_frontend #(
  parameter logic [15:0] ADDR_PORT     = 16'hFC3B,
  parameter logic [15:0] DATA_PORT     = 16'hFD3B,
  parameter int          FILTER_CYCLES = 2,
  parameter logic [7:0]  RESET_ADDR    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  periph_dout,
  input  logic        periph_oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        regaddr_changed,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe_n
);
  localparam logic [3:0] FILT = 4'(FILTER_CYCLES);

  // access kind = {data_port, write}
  localparam logic [1:0] K_ADDR_RD = 2'b00;
  localparam logic [1:0] K_ADDR_WR = 2'b01;
  localparam logic [1:0] K_DATA_RD = 2'b10;
  localparam logic [1:0] K_DATA_WR = 2'b11;

  typedef enum logic [1:0] {IDLE, QUAL, ACTIVE} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] kind, kind_nx, dec;
  logic       dir_ok, hit_addr, hit_data, dec_vld;
  logic       armed, accept, addr_pend;

  always_comb begin
    hit_addr = (cpu_addr == ADDR_PORT);
    hit_data = (cpu_addr == DATA_PORT);
    dir_ok   = !iorq_n && m1_n && (rd_n ^ wr_n);
    dec      = {hit_data, !wr_n};
`ifdef ZXUNO_ADDR_READBACK_EN
    dec_vld  = dir_ok && (hit_data || hit_addr);
`else
    dec_vld  = dir_ok && (hit_data || (hit_addr && !wr_n));
`endif
  end

  // armed means the previous cycle had no decode, so only fresh strobes qualify
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    kind_nx  = kind;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (dec_vld && armed) begin
          kind_nx = dec;
          if (FILT <= 4'd1) begin
            state_nx = ACTIVE;
            cnt_nx   = FILT;
            accept   = 1'b1;
          end else begin
            state_nx = QUAL;
            cnt_nx   = 4'd1;
          end
        end
      end
      QUAL: begin
        if (!dec_vld || dec != kind) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt + 4'd1 >= FILT) begin
          state_nx = ACTIVE;
          cnt_nx   = FILT;
          accept   = 1'b1;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      ACTIVE: begin
        if (!dec_vld || dec != kind) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      kind            <= K_ADDR_RD;
      armed           <= 1'b0;
      addr_pend       <= 1'b0;
      zxuno_addr      <= RESET_ADDR;
      din             <= 8'h00;
      regaddr_changed <= 1'b0;
      zxuno_regrd     <= 1'b0;
      zxuno_regwr     <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      kind            <= kind_nx;
      armed           <= !dec_vld;
      addr_pend       <= accept && (dec == K_ADDR_WR);
      regaddr_changed <= addr_pend;
      if (accept && dec == K_ADDR_WR) zxuno_addr <= cpu_dout;
      if (accept && dec == K_DATA_WR) din <= cpu_dout;
      zxuno_regwr     <= (state_nx == ACTIVE) && (kind_nx == K_DATA_WR);
      zxuno_regrd     <= (state_nx == ACTIVE) && (kind_nx == K_DATA_RD);
    end
  end

  always_comb begin
    dout = 8'hFF;
    oe_n = 1'b1;
    if (state == ACTIVE && kind == K_DATA_RD) begin
      dout = periph_dout;
      oe_n = periph_oe_n;
    end
`ifdef ZXUNO_ADDR_READBACK_EN
    if (state == ACTIVE && kind == K_ADDR_RD) begin
      dout = zxuno_addr;
      oe_n = 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_zxuno_regbus_frontend.sv
// Randomized scoreboard bench for zxuno_regbus_frontend: bus-cycle tasks push
// expected register-bus events, a negedge monitor pops and checks them.
module tb_zxuno_regbus_frontend;
  localparam int          F     = 2;
  localparam logic [15:0] APORT = 16'hFC3B;
  localparam logic [15:0] DPORT = 16'hFD3B;
`ifdef ZXUNO_ADDR_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        iorq_n, rd_n, wr_n, m1_n;
  logic [7:0]  periph_dout;
  logic        periph_oe_n;
  logic [7:0]  zxuno_addr, din, dout;
  logic        regaddr_changed, zxuno_regrd, zxuno_regwr, oe_n;

  zxuno_regbus_frontend #(.FILTER_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .periph_dout(periph_dout), .periph_oe_n(periph_oe_n),
    .zxuno_addr(zxuno_addr), .regaddr_changed(regaddr_changed),
    .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .din(din), .dout(dout), .oe_n(oe_n));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_AW, EV_WR, EV_RD, EV_AR} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] val;
    logic       oe;
    int         cyc;
    int         width;
  } ev_s;

  ev_s        q[$];
  int         checks = 0;
  int         passes = 0;
  logic [7:0] m_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic get_ev(input ev_t k, output ev_s e, output bit ok);
    ok = 1'b0;
    if (q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d, want none (cyc %0d)", k, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", e.kind, k);
      ok = (e.kind == k);
    end
  endtask

  // monitor: detects bus events on rising edges and compares against the queue
  initial begin
    bit   p_rac, p_wr, p_rd, p_ar, rac_pend, wr_open, ok, ar_now;
    int   wr_w, wr_exp;
    ev_s  e;
    p_rac = 0; p_wr = 0; p_rd = 0; p_ar = 0; rac_pend = 0; wr_open = 0;
    wr_w = 0; wr_exp = 0;
    forever begin
      @(negedge clk);
      ar_now = (oe_n == 1'b0) && !zxuno_regrd;
      if (!rst_n) begin
        p_rac = 0; p_wr = 0; p_rd = 0; p_ar = 0; rac_pend = 0; wr_open = 0;
      end else begin
        if (rac_pend) begin
          chk("rac_one_cycle", regaddr_changed, 1'b0);
          rac_pend = 0;
        end
        if (regaddr_changed && !p_rac) begin
          get_ev(EV_AW, e, ok);
          if (ok) begin
            chk("rac_addr", zxuno_addr, e.val);
            chk("rac_cycle", cyc, e.cyc);
          end
          rac_pend = 1;
        end
        if (zxuno_regwr && !p_wr) begin
          get_ev(EV_WR, e, ok);
          if (ok) begin
            chk("regwr_din", din, e.val);
            chk("regwr_cycle", cyc, e.cyc);
          end
          wr_open = ok; wr_w = 1; wr_exp = e.width;
        end else if (zxuno_regwr && wr_open) begin
          wr_w++;
        end
        if (!zxuno_regwr && p_wr && wr_open) begin
          chk("regwr_width", wr_w, wr_exp);
          wr_open = 0;
        end
        if (zxuno_regrd && !p_rd) begin
          get_ev(EV_RD, e, ok);
          if (ok) begin
            chk("regrd_dout", dout, e.val);
            chk("regrd_oe_n", oe_n, e.oe);
            chk("regrd_cycle", cyc, e.cyc);
          end
        end
        if (ar_now && !p_ar) begin
          get_ev(EV_AR, e, ok);
          if (ok) begin
            chk("addr_readback", dout, e.val);
            chk("addr_rb_cycle", cyc, e.cyc);
          end
        end
        p_rac = regaddr_changed; p_wr = zxuno_regwr; p_rd = zxuno_regrd; p_ar = ar_now;
      end
    end
  end

  task automatic idle_bus();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  // typ: 0 addr wr, 1 data wr, 2 data rd, 3 addr rd, 4 int ack, 5 rd+wr low, 6 other port.
  // extra>0 flips the port mid-access (typ 0..2), a new decode that must not be accepted.
  // Called at posedge+2; the strobe is sampled on the next len edges.
  task automatic access(input int typ, input logic [7:0] data, input int len,
                        input logic [7:0] pd, input logic poe, input int extra, input int gap);
    bit         acc;
    ev_s        e;
    logic [7:0] exp_dout;
    logic       exp_oe;
    int         base;
    chk("addr_hold", zxuno_addr, m_addr);
    base = cyc;
    acc  = (len >= F) && (typ <= 2 || (typ == 3 && RB));
    e.val = data; e.oe = 1'b1; e.width = len - F + 1; e.cyc = base + F;
    if (acc) begin
      case (typ)
        0: begin e.kind = EV_AW; e.cyc = base + F + 1; m_addr = data; end
        1: e.kind = EV_WR;
        2: begin e.kind = EV_RD; e.val = pd; e.oe = poe; end
        default: begin e.kind = EV_AR; e.val = m_addr; e.oe = 1'b0; end
      endcase
      q.push_back(e);
    end
    exp_dout = 8'hFF; exp_oe = 1'b1;
    if (acc && typ == 2) begin exp_dout = pd; exp_oe = poe; end
    if (acc && typ == 3) begin exp_dout = m_addr; exp_oe = 1'b0; end

    cpu_dout = data; periph_dout = pd; periph_oe_n = poe;
    iorq_n = 1'b0; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    case (typ)
      0: begin cpu_addr = APORT; wr_n = 1'b0; end
      1: begin cpu_addr = DPORT; wr_n = 1'b0; end
      2: begin cpu_addr = DPORT; rd_n = 1'b0; end
      3: begin cpu_addr = APORT; rd_n = 1'b0; end
      4: begin cpu_addr = APORT; wr_n = 1'b0; m1_n = 1'b0; end
      5: begin cpu_addr = DPORT; wr_n = 1'b0; rd_n = 1'b0; end
      default: begin
        cpu_addr = 16'($urandom);
        if (cpu_addr == APORT || cpu_addr == DPORT) cpu_addr ^= 16'h0100;
        wr_n = 1'b0;
      end
    endcase
    repeat (len) @(posedge clk);
    #2;
    chk("hold_dout", dout, exp_dout);
    chk("hold_oe_n", oe_n, exp_oe);
    chk("hold_regwr", zxuno_regwr, acc && typ == 1);
    chk("hold_regrd", zxuno_regrd, acc && typ == 2);
    if (extra > 0) begin
      cpu_addr = (cpu_addr == APORT) ? DPORT : APORT;
      repeat (extra) @(posedge clk);
      #2;
    end
    idle_bus();
    repeat (1 + gap) @(posedge clk);
    #2;
  endtask

  initial begin
    int typ, len, extra;
    m_addr = 8'h00;
    // strobe already active at reset release must be ignored
    rst_n = 1'b0; cpu_addr = APORT; cpu_dout = 8'h55; periph_dout = 8'h00; periph_oe_n = 1'b1;
    iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; m1_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_addr", zxuno_addr, 8'h00);
    chk("rst_din", din, 8'h00);
    chk("rst_rac", regaddr_changed, 1'b0);
    chk("rst_regrd", zxuno_regrd, 1'b0);
    chk("rst_regwr", zxuno_regwr, 1'b0);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_oe_n", oe_n, 1'b1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("held_strobe_ignored", zxuno_addr, 8'h00);
    idle_bus();
    repeat (2) @(posedge clk);
    #2;

    access(0, 8'hFC, 4, 8'h00, 1'b1, 0, 0);
    access(0, 8'hFC, 4, 8'h00, 1'b1, 0, 1);
    access(0, 8'hFD, 4, 8'h00, 1'b1, 0, 0);
    access(1, 8'h01, 4, 8'h00, 1'b1, 0, 0);
    access(2, 8'h00, 3, 8'h0B, 1'b0, 0, 0);
    access(2, 8'h00, 3, 8'h0B, 1'b1, 0, 0);
    access(1, 8'hEE, 1, 8'h00, 1'b1, 0, 0);
    access(4, 8'h77, 4, 8'h00, 1'b1, 0, 0);
    access(5, 8'h66, 4, 8'h00, 1'b1, 0, 0);
    access(1, 8'h99, 3, 8'h00, 1'b1, 3, 0);
    access(0, 8'h2A, 2, 8'h00, 1'b1, 0, 0);
    access(3, 8'h00, 3, 8'h00, 1'b1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      typ   = $urandom_range(0, 6);
      len   = $urandom_range(1, 5);
      extra = (typ <= 2 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      access(typ, 8'($urandom), len, 8'($urandom), 1'($urandom_range(0, 1)),
             extra, $urandom_range(0, 2));
    end
    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);

    // reset in the middle of an accepted data write
    cpu_addr = DPORT; cpu_dout = 8'h77; iorq_n = 1'b0; wr_n = 1'b0;
    begin
      ev_s e;
      e.kind = EV_WR; e.val = 8'h77; e.oe = 1'b1; e.cyc = cyc + F; e.width = 0;
      q.push_back(e);
    end
    repeat (F + 1) @(posedge clk);
    #2;
    chk("midrst_regwr_before", zxuno_regwr, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_regwr", zxuno_regwr, 1'b0);
    chk("midrst_addr", zxuno_addr, 8'h00);
    chk("midrst_din", din, 8'h00);
    chk("midrst_rac", regaddr_changed, 1'b0);
    chk("midrst_oe_n", oe_n, 1'b1);
    m_addr = 8'h00;
    idle_bus();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    access(0, 8'h3C, 3, 8'h00, 1'b1, 0, 0);
    access(1, 8'hA5, 2, 8'h00, 1'b1, 0, 0);
    access(2, 8'h00, 2, 8'h5A, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained_end", q.size(), 0);
    chk("final_addr", zxuno_addr, m_addr);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
